// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS32 core slice.
//  - Opcode constants and instruction-type codes used by the decode stages.
//  - Memory arbiter FSM state and owner encodings.
//  - Default memory geometry (1024 x 32 unified memory).
package mips_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] SUB   = 6'b000001;
  localparam logic [5:0] AND   = 6'b000010;
  localparam logic [5:0] OR    = 6'b000011;
  localparam logic [5:0] SLT   = 6'b000100;
  localparam logic [5:0] MUL   = 6'b000101;
  localparam logic [5:0] LW    = 6'b001000;
  localparam logic [5:0] SW    = 6'b001001;
  localparam logic [5:0] ADDI  = 6'b001010;
  localparam logic [5:0] SUBI  = 6'b001011;
  localparam logic [5:0] SLTI  = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [5:0] BEQZ  = 6'b001110;
  localparam logic [5:0] HLT   = 6'b111111;

  // Instruction-type codes carried down the pipeline
  localparam logic [2:0] RR_ALU = 3'd0;
  localparam logic [2:0] RM_ALU = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] STORE  = 3'd3;
  localparam logic [2:0] BRANCH = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

  // Map an opcode onto its instruction type (unknown opcodes decode as HALT).
  function automatic logic [2:0] instr_type(input logic [5:0] op);
    logic [2:0] t;
    t = HALT;
    case (op)
      ADD, SUB, AND, OR, SLT, MUL: t = RR_ALU;
      ADDI, SUBI, SLTI:            t = RM_ALU;
      LW:                          t = LOAD;
      SW:                          t = STORE;
      BNEQZ, BEQZ:                 t = BRANCH;
      default:                     t = HALT;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips_arb_pick.sv
// Winner select for the memory arbiter plus the IF starvation counter.
// Ports:
//  clk1, rst_n      clock, synchronous active-low reset
//  if_req, dm_req   pending requests
//  arb_en           arbiter is free to grant this cycle
//  if_win, dm_win   combinational one-hot winner (both 0 when no grant)
// Data wins ties, except once IF has lost STARVE_MAX arbitrations in a row.
module mips_arb_pick #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_req,
  input  logic arb_en,
  output logic if_win,
  output logic dm_win
);

  logic [3:0] starve_cnt;

  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (arb_en) begin
      if (if_req && (!dm_req || starve_cnt == 4'(STARVE_MAX))) if_win = 1'b1;
      else if (dm_req)                                          dm_win = 1'b1;
    end
  end

  // Count only arbitrations IF actually lost; a dropped if_req forgives history.
  always_ff @(posedge clk1) begin
    if (!rst_n)                    starve_cnt <= '0;
    else if (!if_req || if_win)    starve_cnt <= '0;
    else if (dm_win && starve_cnt != 4'(STARVE_MAX))
                                   starve_cnt <= starve_cnt + 4'd1;
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares the unified 1024x32 memory between IF fetch and MEM-stage data access.
// One access in flight; IDLE -> ACCESS -> RESP -> IDLE; every output is registered.
// Ports:
//  clk1, rst_n                          clock, synchronous active-low reset
//  if_req/if_addr/if_flush              fetch request, address, taken-branch flush
//  if_gnt/if_rvalid/if_rdata            fetch issued, instruction valid, instruction
//  dm_req/dm_we/dm_addr/dm_wdata        data request (load/store)
//  dm_gnt/dm_ack/dm_rdata               data issued, load data valid / store done, load data
//  mem_en/mem_we/mem_addr/mem_wdata     memory strobe and command
//  mem_rdata                            memory read data, MEM_LAT cycles after the mem_en cycle
//  busy                                 access in progress
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = 3;

  arb_state_t        state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic              flushed, flushed_nxt;
  logic              acc_we, acc_we_nxt;
  logic              if_win, dm_win, flush_hit;

  logic              if_gnt_d, dm_gnt_d, if_rvalid_d, dm_ack_d, mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;

  mips_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .if_req (if_req),
    .dm_req (dm_req),
    .arb_en (state == IDLE),
    .if_win (if_win),
    .dm_win (dm_win)
  );

  assign busy      = (state != IDLE);
  assign flush_hit = if_flush && (owner == OWN_IF) && (state != IDLE);

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    lat_cnt_nxt = lat_cnt;
    flushed_nxt = flushed;
    acc_we_nxt  = acc_we;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_ack_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    case (state)
      IDLE: begin
        flushed_nxt = 1'b0;
        if (dm_win) begin
          dm_gnt_d    = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          owner_nxt   = OWN_DM;
          acc_we_nxt  = dm_we;
          lat_cnt_nxt = LAT_W'(MEM_LAT);
          state_nxt   = ACCESS;
        end else if (if_win) begin
          if_gnt_d    = 1'b1;
          mem_en_d    = 1'b1;
          mem_addr_d  = if_addr;
          owner_nxt   = OWN_IF;
          acc_we_nxt  = 1'b0;
          lat_cnt_nxt = LAT_W'(MEM_LAT);
          state_nxt   = ACCESS;
        end
      end
      ACCESS: begin
        if (flush_hit) flushed_nxt = 1'b1;
        // ACCESS spans the mem_en cycle plus MEM_LAT cycles, so the capture
        // edge is the one closing the cycle in which mem_rdata is valid.
        if (lat_cnt == '0) begin
          state_nxt = RESP;
          if (owner == OWN_DM) begin
            dm_ack_d = 1'b1;
            if (!acc_we) dm_rdata_d = mem_rdata;
          end else if (flushed || flush_hit) begin
            if_rdata_d = '0;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end
      RESP: begin
        state_nxt   = IDLE;
        flushed_nxt = 1'b0;
        // Pulse already on the wire; don't leave the dead instruction on the bus.
        if (flush_hit) if_rdata_d = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lat_cnt   <= '0;
      flushed   <= 1'b0;
      acc_we    <= 1'b0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_ack    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      lat_cnt   <= lat_cnt_nxt;
      flushed   <= flushed_nxt;
      acc_we    <= acc_we_nxt;
      if_gnt    <= if_gnt_d;
      dm_gnt    <= dm_gnt_d;
      if_rvalid <= if_rvalid_d;
      dm_ack    <= dm_ack_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter (MEM_LAT=1, STARVE_MAX=3).
// A one-cycle-latency memory model returns word data only in the cycle after mem_en.
module tb_mips_mem_arbiter;

  logic        clk1, rst_n;
  logic        if_req, if_flush, dm_req, dm_we;
  logic [9:0]  if_addr, dm_addr;
  logic [31:0] dm_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_ack, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_wdata;
  logic [9:0]  mem_addr;

  int n_chk = 0;
  int n_fail = 0;

  mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    if (a == 10'h005) return 32'h12345678;
    return 32'hA5000000 | {22'd0, a};
  endfunction

  always @(posedge clk1)
    mem_rdata <= (mem_en && !mem_we) ? mem_word(mem_addr) : 32'h0;

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; if_flush = 1'b0;
    dm_we = 1'b0; if_addr = 10'h0; dm_addr = 10'h0; dm_wdata = 32'h0;

    // 1: reset held with both requests up
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst ctl", {25'd0, if_gnt, dm_gnt, dm_ack, if_rvalid, mem_en, mem_we, busy}, 32'h0);
    end
    chk("rst mem_addr", {22'd0, mem_addr}, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst dm_rdata", dm_rdata, 32'h0);
    if_req = 1'b0; dm_req = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("idle busy", busy, 1'b0);

    // 2: lone fetch
    if_req = 1'b1; if_addr = 10'h005;
    tick;
    chk("t2 if_gnt", if_gnt, 1'b1);
    chk("t2 dm_gnt", dm_gnt, 1'b0);
    chk("t2 mem_en", mem_en, 1'b1);
    chk("t2 mem_we", mem_we, 1'b0);
    chk("t2 mem_addr", {22'd0, mem_addr}, 32'h005);
    chk("t2 busy", busy, 1'b1);
    if_req = 1'b0;
    tick;
    chk("t2 c2 strobes", {30'd0, mem_en, if_rvalid}, 32'h0);
    tick;
    chk("t2 if_rvalid", if_rvalid, 1'b1);
    chk("t2 if_rdata", if_rdata, 32'h12345678);
    tick;
    chk("t2 c4 rvalid", if_rvalid, 1'b0);
    chk("t2 c4 busy", busy, 1'b0);

    // 3: store beats a simultaneous fetch
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h010; dm_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 10'h040;
    tick;
    chk("t3 dm_gnt", dm_gnt, 1'b1);
    chk("t3 if_gnt", if_gnt, 1'b0);
    chk("t3 mem_we", mem_we, 1'b1);
    chk("t3 mem_addr", {22'd0, mem_addr}, 32'h010);
    chk("t3 mem_wdata", mem_wdata, 32'hDEADBEEF);
    dm_req = 1'b0; dm_we = 1'b0;
    tick; tick;
    chk("t3 dm_ack", dm_ack, 1'b1);
    chk("t3 dm_rdata kept", dm_rdata, 32'h0);
    tick;
    chk("t3 c4 if_gnt", if_gnt, 1'b0);
    tick;
    chk("t3 c5 if_gnt", if_gnt, 1'b1);
    chk("t3 c5 mem_addr", {22'd0, mem_addr}, 32'h040);
    chk("t3 c5 mem_we", mem_we, 1'b0);
    if_req = 1'b0;
    tick; tick;
    chk("t3 if_rvalid", if_rvalid, 1'b1);
    chk("t3 if_rdata", if_rdata, mem_word(10'h040));
    tick;

    // 4: starvation guard
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h030;
    if_req = 1'b1; if_addr = 10'h050;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t4 dm_gnt", dm_gnt, k < 3);
      chk("t4 if_gnt", if_gnt, k == 3);
      tick; tick;
      if (k < 3) begin
        chk("t4 dm_ack", dm_ack, 1'b1);
        chk("t4 dm_rdata", dm_rdata, mem_word(10'h030));
      end else begin
        chk("t4 if_rvalid", if_rvalid, 1'b1);
        chk("t4 if_rdata", if_rdata, mem_word(10'h050));
      end
      tick;
    end
    tick;
    chk("t4 after dm_gnt", dm_gnt, 1'b1);
    chk("t4 after if_gnt", if_gnt, 1'b0);
    dm_req = 1'b0; if_req = 1'b0;
    tick; tick; tick;

    // 5: flush in the grant cycle kills the fetch response
    if_req = 1'b1; if_addr = 10'h060;
    tick;
    chk("t5 if_gnt", if_gnt, 1'b1);
    if_req = 1'b0; if_flush = 1'b1;
    tick;
    if_flush = 1'b0;
    tick;
    chk("t5 no rvalid", if_rvalid, 1'b0);
    chk("t5 busy resp", busy, 1'b1);
    tick;
    chk("t5 c4 rvalid", if_rvalid, 1'b0);
    // following load, with a stray flush that must be ignored
    dm_req = 1'b1; dm_addr = 10'h020;
    tick;
    chk("t5 dm_gnt", dm_gnt, 1'b1);
    chk("t5 mem_addr", {22'd0, mem_addr}, 32'h020);
    dm_req = 1'b0;
    tick;
    if_flush = 1'b1;
    tick;
    if_flush = 1'b0;
    chk("t5 dm_ack", dm_ack, 1'b1);
    chk("t5 dm_rdata", dm_rdata, mem_word(10'h020));
    tick;
    // flush while idle must not affect the next fetch
    if_flush = 1'b1; if_req = 1'b1; if_addr = 10'h070;
    tick;
    if_flush = 1'b0; if_req = 1'b0;
    chk("t5b if_gnt", if_gnt, 1'b1);
    tick; tick;
    chk("t5b if_rvalid", if_rvalid, 1'b1);
    chk("t5b if_rdata", if_rdata, mem_word(10'h070));
    tick;

    // 6: reset during a load abandons it
    dm_req = 1'b1; dm_addr = 10'h030;
    tick;
    chk("t6 dm_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("t6 rst ctl", {25'd0, if_gnt, dm_gnt, dm_ack, if_rvalid, mem_en, mem_we, busy}, 32'h0);
    chk("t6 rst dm_rdata", dm_rdata, 32'h0);
    tick;
    chk("t6 no ack 1", dm_ack, 1'b0);
    if_req = 1'b1; if_addr = 10'h005;
    tick;
    chk("t6 no ack 2", dm_ack, 1'b0);
    chk("t6 if_gnt", if_gnt, 1'b1);
    chk("t6 mem_addr", {22'd0, mem_addr}, 32'h005);
    if_req = 1'b0;
    tick; tick;
    chk("t6 if_rvalid", if_rvalid, 1'b1);
    chk("t6 if_rdata", if_rdata, 32'h12345678);
    chk("t6 no ack 3", dm_ack, 1'b0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
